// File: rtl/arp_pkg.sv
// Shared ARP/Ethernet field offsets, header constants, FSM state type and request payload.
package arp_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned MAC_W  = 48;
    localparam int unsigned IP_W   = 32;
    localparam int unsigned OFF_W  = 6;

    localparam int unsigned OFF_DA    = 0;
    localparam int unsigned OFF_ETYPE = 12;
    localparam int unsigned OFF_HTYPE = 14;
    localparam int unsigned OFF_PTYPE = 16;
    localparam int unsigned OFF_HLEN  = 18;
    localparam int unsigned OFF_PLEN  = 19;
    localparam int unsigned OFF_OPER  = 20;
    localparam int unsigned OFF_SHA   = 22;
    localparam int unsigned OFF_SPA   = 28;
    localparam int unsigned OFF_THA   = 32;
    localparam int unsigned OFF_TPA   = 38;
    localparam int unsigned OFF_LAST  = 41;

    localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
    localparam logic [15:0] HTYPE_ETH    = 16'h0001;
    localparam logic [15:0] PTYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  HLEN_ETH     = 8'h06;
    localparam logic [7:0]  PLEN_IPV4    = 8'h04;
    localparam logic [15:0] OP_REQUEST   = 16'h0001;
    localparam logic [47:0] BCAST_MAC    = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_COMMIT,
        ST_TAIL
    } state_t;

    typedef struct packed {
        logic [MAC_W-1:0] sha;
        logic [IP_W-1:0]  spa;
    } arp_req_t;

    // Fixed header byte expected at an offset: {check_enable, value}.
    function automatic logic [8:0] hdr_expect(input logic [OFF_W-1:0] off);
        case (off)
            6'(OFF_ETYPE):     return {1'b1, ETH_TYPE_ARP[15:8]};
            6'(OFF_ETYPE + 1): return {1'b1, ETH_TYPE_ARP[7:0]};
            6'(OFF_HTYPE):     return {1'b1, HTYPE_ETH[15:8]};
            6'(OFF_HTYPE + 1): return {1'b1, HTYPE_ETH[7:0]};
            6'(OFF_PTYPE):     return {1'b1, PTYPE_IPV4[15:8]};
            6'(OFF_PTYPE + 1): return {1'b1, PTYPE_IPV4[7:0]};
            6'(OFF_HLEN):      return {1'b1, HLEN_ETH};
            6'(OFF_PLEN):      return {1'b1, PLEN_IPV4};
            6'(OFF_OPER):      return {1'b1, OP_REQUEST[15:8]};
            6'(OFF_OPER + 1):  return {1'b1, OP_REQUEST[7:0]};
            default:           return 9'd0;
        endcase
    endfunction

endpackage

// File: rtl/arp_req_fifo.sv
// First-word fall-through sync FIFO for pending ARP requests; push into a full FIFO is
// allowed when a pop happens in the same cycle.
module arp_req_fifo #(
    parameter int unsigned WIDTH = 82,
    parameter int unsigned DEPTH = 4
) (
    input  logic             CLK_RX,
    input  logic             ARESET,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout_c,
    output logic             o_full_c,
    output logic             o_empty_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_full_c  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty_c = (r_cnt == '0);
    assign w_pop     = i_pop && !o_empty_c;
    assign w_push    = i_push && (!o_full_c || w_pop);
    // Head is masked while empty so the outputs read zero after reset and after draining.
    assign o_dout_c  = o_empty_c ? '0 : r_mem[r_rd];

    always_ff @(posedge CLK_RX) begin
        if (w_push) begin
            r_mem[r_wr] <= i_din;
        end
    end

    always_ff @(posedge CLK_RX) begin
        if (ARESET) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/arp_req_parser_multi.sv
// ARP request parser: validates header bytes, matches TPA against NUM_IP local addresses
// and queues accepted {SHA, SPA, index} for the reply generator.
module arp_req_parser_multi
    import arp_pkg::*;
#(
    parameter int unsigned NUM_IP      = 4,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned CHECK_DA    = 1,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned IDX_W      = (NUM_IP > 1) ? $clog2(NUM_IP) : 1
) (
    input  logic                   CLK_RX,
    input  logic                   ARESET,
    input  logic [47:0]            MY_MAC,
    input  logic [32*NUM_IP-1:0]   MY_IPV4,
    input  logic [NUM_IP-1:0]      IP_EN,
    input  logic                   DATA_VALID_RX,
    input  logic [7:0]             DATA_RX,
    output logic                   REQ_VALID,
    input  logic                   REQ_READY,
    output logic [47:0]            REQ_SHA,
    output logic [31:0]            REQ_SPA,
    output logic [IDX_W-1:0]       REQ_IDX,
    output logic [CNT_W-1:0]       REQ_CNT,
    output logic [CNT_W-1:0]       DROP_CNT
);

    localparam int unsigned FIFO_W = MAC_W + IP_W + IDX_W;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_valid_q;
    logic [OFF_W-1:0]   r_off;
    logic               r_ok;
    logic               r_da_bc;
    logic               r_da_my;
    logic [NUM_IP-1:0]  r_match;
    logic [MAC_W-1:0]   r_sha;
    logic [IP_W-1:0]    r_spa;
    logic [CNT_W-1:0]   r_req_cnt;
    logic [CNT_W-1:0]   r_drop_cnt;

    logic               w_start;
    logic               w_first;
    logic               w_take;
    logic [OFF_W-1:0]   w_off;
    logic [7:0]         w_mac_byte;
    logic [8:0]         w_exp;
    logic               w_bc;
    logic               w_my;
    logic               w_fail;
    logic               w_ok_nxt;
    logic [1:0]         w_tpa_k;
    logic [NUM_IP-1:0]  w_eq;
    logic [NUM_IP-1:0]  w_match_nxt;
    logic               w_accept;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    arp_req_t           w_req_in;
    logic [FIFO_W-1:0]  w_dout;

    function automatic logic [IDX_W-1:0] f_lowest(input logic [NUM_IP-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_IP - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    assign w_start = DATA_VALID_RX && !r_valid_q;
    assign w_first = (r_state == ST_IDLE);
    assign w_take  = (w_first && w_start) || ((r_state == ST_HDR) && DATA_VALID_RX);
    assign w_off   = w_first ? '0 : r_off;
    assign w_tpa_k = 2'(w_off - 6'(OFF_TPA));

    // Per-byte header checks; DA is tracked as two sticky candidates (broadcast / own MAC).
    always_comb begin
        w_mac_byte = '0;
        for (int k = 0; k < 6; k++) begin
            if (w_off == 6'(k)) begin
                w_mac_byte = MY_MAC[MAC_W-BYTE_W-BYTE_W*k +: BYTE_W];
            end
        end
        w_exp    = hdr_expect(w_off);
        w_bc     = (w_first || r_da_bc) && (DATA_RX == 8'hFF);
        w_my     = (w_first || r_da_my) && (DATA_RX == w_mac_byte);
        w_fail   = (w_exp[8] && (DATA_RX != w_exp[7:0]))
                || ((CHECK_DA != 0) && (w_off == 6'(OFF_DA + 5)) && !(w_bc || w_my));
        w_ok_nxt = (w_first || r_ok) && !w_fail;
    end

    always_comb begin
        w_eq = '0;
        for (int i = 0; i < NUM_IP; i++) begin
            w_eq[i] = (DATA_RX == MY_IPV4[IP_W*i + BYTE_W*(3 - int'(w_tpa_k)) +: BYTE_W]);
        end
        w_match_nxt = ((w_off == 6'(OFF_TPA)) ? IP_EN : r_match) & w_eq;
    end

    always_ff @(posedge CLK_RX) begin
        if (ARESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_push      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                if (!DATA_VALID_RX) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_off == 6'(OFF_LAST)) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_accept    = r_ok && (|r_match);
                w_push      = w_accept && (!w_full || w_pop);
                w_drop      = w_accept && !w_push;
                // Going straight to IDLE keeps a one-cycle gap after a 42-byte frame usable.
                w_state_nxt = DATA_VALID_RX ? ST_TAIL : ST_IDLE;
            end
            ST_TAIL: begin
                if (!DATA_VALID_RX) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_RX) begin
        if (ARESET) begin
            r_valid_q <= 1'b1;
            r_off     <= '0;
            r_ok      <= 1'b0;
            r_da_bc   <= 1'b0;
            r_da_my   <= 1'b0;
            r_match   <= '0;
            r_sha     <= '0;
            r_spa     <= '0;
        end else begin
            r_valid_q <= DATA_VALID_RX;
            if (w_take) begin
                r_off   <= w_off + 6'd1;
                r_ok    <= w_ok_nxt;
                r_da_bc <= w_bc;
                r_da_my <= w_my;
                if ((w_off >= 6'(OFF_SHA)) && (w_off < 6'(OFF_SPA))) begin
                    r_sha <= {r_sha[MAC_W-BYTE_W-1:0], DATA_RX};
                end
                if ((w_off >= 6'(OFF_SPA)) && (w_off < 6'(OFF_THA))) begin
                    r_spa <= {r_spa[IP_W-BYTE_W-1:0], DATA_RX};
                end
                if (w_off >= 6'(OFF_TPA)) begin
                    r_match <= w_match_nxt;
                end
            end
        end
    end

    // Saturating accept/drop counters.
    always_ff @(posedge CLK_RX) begin
        if (ARESET) begin
            r_req_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push && (r_req_cnt != '1)) begin
                r_req_cnt <= r_req_cnt + CNT_W'(1);
            end
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign w_req_in = '{sha: r_sha, spa: r_spa};
    assign w_pop    = !w_empty && REQ_READY;

    arp_req_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .CLK_RX    (CLK_RX),
        .ARESET    (ARESET),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_din     ({w_req_in, f_lowest(r_match)}),
        .o_dout_c  (w_dout),
        .o_full_c  (w_full),
        .o_empty_c (w_empty)
    );

    assign REQ_VALID                   = !w_empty;
    assign {REQ_SHA, REQ_SPA, REQ_IDX} = w_dout;
    assign REQ_CNT                     = r_req_cnt;
    assign DROP_CNT                    = r_drop_cnt;

endmodule

// File: tb/tb_arp_req_parser_multi.sv
// Randomized and directed bench for arp_req_parser_multi against a frame-level reference model.
module tb_arp_req_parser_multi;

    localparam int unsigned NUM_IP   = 4;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned CHECK_DA = 1;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned IDX_W    = 2;

    logic                 CLK_RX = 1'b0;
    logic                 ARESET;
    logic [47:0]          MY_MAC;
    logic [32*NUM_IP-1:0] MY_IPV4;
    logic [NUM_IP-1:0]    IP_EN;
    logic                 DATA_VALID_RX;
    logic [7:0]           DATA_RX;
    logic                 REQ_VALID;
    logic                 REQ_READY;
    logic [47:0]          REQ_SHA;
    logic [31:0]          REQ_SPA;
    logic [IDX_W-1:0]     REQ_IDX;
    logic [CNT_W-1:0]     REQ_CNT;
    logic [CNT_W-1:0]     DROP_CNT;

    always #5 CLK_RX = ~CLK_RX;

    arp_req_parser_multi #(
        .NUM_IP      (NUM_IP),
        .QUEUE_DEPTH (DEPTH),
        .CHECK_DA    (CHECK_DA),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK_RX        (CLK_RX),
        .ARESET        (ARESET),
        .MY_MAC        (MY_MAC),
        .MY_IPV4       (MY_IPV4),
        .IP_EN         (IP_EN),
        .DATA_VALID_RX (DATA_VALID_RX),
        .DATA_RX       (DATA_RX),
        .REQ_VALID     (REQ_VALID),
        .REQ_READY     (REQ_READY),
        .REQ_SHA       (REQ_SHA),
        .REQ_SPA       (REQ_SPA),
        .REQ_IDX       (REQ_IDX),
        .REQ_CNT       (REQ_CNT),
        .DROP_CNT      (DROP_CNT)
    );

    typedef struct {
        logic [47:0] sha;
        logic [31:0] spa;
        logic [1:0]  idx;
    } ent_t;

    int   n_checks = 0;
    int   n_errors = 0;
    ent_t mq[$];
    int   exp_req;
    int   exp_drop;
    bit   pend;
    bit   pend_acc;
    ent_t pend_ent;
    bit   rnd_rdy;
    logic [7:0] fr [0:63];
    int   fr_len;
    int   base;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ip_of(input int i);
        return MY_IPV4[32*i +: 32];
    endfunction

    function automatic logic [63:0] field(input int off, input int n);
        logic [63:0] v = 0;
        for (int k = 0; k < n; k++) v = (v << 8) | 64'(fr[off+k]);
        return v;
    endfunction

    // Whole-frame verdict from field values, independent of byte timing.
    task automatic evaluate(output bit acc, output ent_t e);
        logic [47:0] da = 48'(field(0, 6));
        logic [31:0] tpa = 32'(field(38, 4));
        bit ok;
        int idx = -1;
        ok = ((CHECK_DA == 0) || da == 48'hFFFF_FFFF_FFFF || da == MY_MAC)
          && field(12, 2) == 64'h0806 && field(14, 2) == 64'h0001
          && field(16, 2) == 64'h0800 && fr[18] == 8'h06 && fr[19] == 8'h04
          && field(20, 2) == 64'h0001;
        for (int i = NUM_IP - 1; i >= 0; i--)
            if (IP_EN[i] && tpa == ip_of(i)) idx = i;
        acc   = ok && (idx >= 0);
        e.sha = 48'(field(22, 6));
        e.spa = 32'(field(28, 4));
        e.idx = (idx >= 0) ? 2'(idx) : 2'd0;
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic rst);
        bit pop;
        if (rnd_rdy) REQ_READY = 1'($urandom_range(0, 1));
        DATA_VALID_RX = v;
        DATA_RX       = d;
        ARESET        = rst;
        pop = (mq.size() != 0) && REQ_READY;
        @(posedge CLK_RX);
        if (rst) begin
            mq.delete();
            exp_req  = 0;
            exp_drop = 0;
            pend     = 0;
        end else begin
            if (pop) mq.delete(0);
            if (pend) begin
                pend = 0;
                if (pend_acc) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back(pend_ent);
                        if (exp_req < 65535) exp_req++;
                    end else if (exp_drop < 65535) begin
                        exp_drop++;
                    end
                end
            end
        end
        #1;
        check_eq("req_valid", 64'(REQ_VALID), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            check_eq("req_sha", 64'(REQ_SHA), 64'(mq[0].sha));
            check_eq("req_spa", 64'(REQ_SPA), 64'(mq[0].spa));
            check_eq("req_idx", 64'(REQ_IDX), 64'(mq[0].idx));
        end
        if (rst) begin
            check_eq("rst_sha", 64'(REQ_SHA), 64'd0);
            check_eq("rst_spa", 64'(REQ_SPA), 64'd0);
            check_eq("rst_idx", 64'(REQ_IDX), 64'd0);
        end
        check_eq("req_cnt", 64'(REQ_CNT), 64'(exp_req));
        check_eq("drop_cnt", 64'(DROP_CNT), 64'(exp_drop));
    endtask

    task automatic build(input logic [47:0] da, input logic [15:0] op, input logic [47:0] sha,
                         input logic [31:0] spa, input logic [31:0] tpa, input int pad);
        logic [15:0] et = 16'h0806;
        logic [15:0] ht = 16'h0001;
        logic [15:0] pt = 16'h0800;
        for (int k = 0; k < 6; k++) begin
            fr[k]      = da[8*(5-k) +: 8];
            fr[6+k]    = 8'($urandom);
            fr[22+k]   = sha[8*(5-k) +: 8];
            fr[32+k]   = 8'($urandom);
        end
        fr[12] = et[15:8]; fr[13] = et[7:0];
        fr[14] = ht[15:8]; fr[15] = ht[7:0];
        fr[16] = pt[15:8]; fr[17] = pt[7:0];
        fr[18] = 8'h06;    fr[19] = 8'h04;
        fr[20] = op[15:8]; fr[21] = op[7:0];
        for (int k = 0; k < 4; k++) begin
            fr[28+k] = spa[8*(3-k) +: 8];
            fr[38+k] = tpa[8*(3-k) +: 8];
        end
        for (int k = 42; k < 64; k++) fr[k] = 8'($urandom);
        fr_len = 42 + pad;
    endtask

    task automatic send(input int len, input int rst_at, input int gap);
        bit   live = 1;
        bit   acc;
        ent_t e;
        evaluate(acc, e);
        for (int i = 0; i < len; i++) begin
            if (i == rst_at) live = 0;
            step(1'b1, fr[i], 1'(i == rst_at));
            if (live && i == 41) begin
                pend     = 1;
                pend_acc = acc;
                pend_ent = e;
            end
        end
        for (int g = 0; g < gap; g++) step(1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic drain(input int cycles);
        REQ_READY = 1'b1;
        for (int c = 0; c < cycles; c++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [47:0] da;
        logic [31:0] tpa;
        int          kind;
        int          len;

        rnd_rdy       = 0;
        MY_MAC        = 48'h02AA_BBCC_DDEE;
        MY_IPV4       = {32'h0A000004, 32'h0A000003, 32'h0A000002, 32'h0A000001};
        IP_EN         = 4'hF;
        REQ_READY     = 1'b0;
        DATA_VALID_RX = 1'b0;
        DATA_RX       = 8'h00;
        ARESET        = 1'b1;
        exp_req = 0; exp_drop = 0; pend = 0;

        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // 1: broadcast request to entry 1; head appears on the second edge after byte 41.
        build(48'hFFFF_FFFF_FFFF, 16'h0001, 48'h0200_0000_0001, 32'h0A000009, 32'h0A000002, 0);
        send(42, -1, 0);
        check_eq("t1_not_yet", 64'(REQ_VALID), 64'd0);
        step(1'b0, 8'h00, 1'b0);
        check_eq("t1_valid", 64'(REQ_VALID), 64'd1);
        check_eq("t1_sha", 64'(REQ_SHA), 64'h0200_0000_0001);
        check_eq("t1_spa", 64'(REQ_SPA), 64'h0A000009);
        check_eq("t1_idx", 64'(REQ_IDX), 64'd1);
        check_eq("t1_cnt", 64'(REQ_CNT), 64'd1);
        drain(2);

        // 2: reply opcode and foreign unicast DA are both rejected.
        base = int'(REQ_CNT);
        build(48'hFFFF_FFFF_FFFF, 16'h0002, 48'h0200_0000_0002, 32'h0A000010, 32'h0A000001, 3);
        send(fr_len, -1, 1);
        build(48'hAABB_CCDD_EEFF, 16'h0001, 48'h0200_0000_0003, 32'h0A000011, 32'h0A000001, 0);
        send(fr_len, -1, 2);
        check_eq("t2_cnt", 64'(REQ_CNT), 64'(base));
        check_eq("t2_valid", 64'(REQ_VALID), 64'd0);

        // 3: disabled entry never matches; duplicate entries report the lowest enabled index.
        IP_EN = 4'b1011;
        build(MY_MAC, 16'h0001, 48'h0200_0000_0004, 32'h0A000012, 32'h0A000003, 0);
        send(42, -1, 2);
        check_eq("t3_disabled", 64'(REQ_VALID), 64'd0);
        MY_IPV4 = {32'h0A000002, 32'h0A000003, 32'h0A000002, 32'h0A000001};
        IP_EN   = 4'b1010;
        REQ_READY = 1'b0;
        build(MY_MAC, 16'h0001, 48'h0200_0000_0005, 32'h0A000013, 32'h0A000002, 0);
        send(42, -1, 1);
        check_eq("t3_idx", 64'(REQ_IDX), 64'd1);
        drain(2);
        MY_IPV4 = {32'h0A000004, 32'h0A000003, 32'h0A000002, 32'h0A000001};
        IP_EN   = 4'hF;

        // 4: overflow by one, then drain in arrival order.
        base      = int'(DROP_CNT);
        REQ_READY = 1'b0;
        for (int f = 0; f < DEPTH + 1; f++) begin
            build(48'hFFFF_FFFF_FFFF, 16'h0001, 48'h0200_0000_0100, 32'hC0A80000 + 32'(f),
                  32'h0A000004, 0);
            send(42, -1, 1);
        end
        step(1'b0, 8'h00, 1'b0);
        check_eq("t4_drop", 64'(DROP_CNT), 64'(base + 1));
        check_eq("t4_head", 64'(REQ_SPA), 64'hC0A80000);
        drain(DEPTH + 1);
        check_eq("t4_empty", 64'(REQ_VALID), 64'd0);

        // 5: frame aborted at offset 30, good frame after a single idle cycle.
        base = int'(REQ_CNT);
        build(48'hFFFF_FFFF_FFFF, 16'h0001, 48'h0200_0000_0006, 32'h0A000014, 32'h0A000001, 0);
        send(30, -1, 1);
        build(48'hFFFF_FFFF_FFFF, 16'h0001, 48'h0200_0000_0007, 32'h0A000015, 32'h0A000001, 2);
        send(fr_len, -1, 2);
        check_eq("t5_cnt", 64'(REQ_CNT), 64'(base + 1));

        // 6: reset mid-frame with two queued entries; the next frame is accepted.
        REQ_READY = 1'b0;
        for (int f = 0; f < 2; f++) begin
            build(MY_MAC, 16'h0001, 48'h0200_0000_0200, 32'h0A000020 + 32'(f), 32'h0A000003, 0);
            send(42, -1, 1);
        end
        check_eq("t6_queued", 64'(REQ_VALID), 64'd1);
        build(48'hFFFF_FFFF_FFFF, 16'h0001, 48'h0200_0000_0300, 32'h0A000030, 32'h0A000001, 6);
        send(fr_len, 20, 2);
        check_eq("t6_flushed", 64'(REQ_VALID), 64'd0);
        build(48'hFFFF_FFFF_FFFF, 16'h0001, 48'h0200_0000_0301, 32'h0A000031, 32'h0A000002, 0);
        send(42, -1, 1);
        check_eq("t6_accept", 64'(REQ_CNT), 64'd1);

        // Random frames with random backpressure and entry enables.
        rnd_rdy = 1;
        for (int f = 0; f < 80; f++) begin
            IP_EN = 4'($urandom);
            kind  = $urandom_range(0, 9);
            da    = (kind < 4) ? 48'hFFFF_FFFF_FFFF : (kind < 8) ? MY_MAC
                                                     : {16'($urandom), 32'($urandom)};
            tpa   = ($urandom_range(0, 4) != 0) ? ip_of($urandom_range(0, NUM_IP - 1))
                                                : 32'($urandom);
            build(da, ($urandom_range(0, 9) == 0) ? 16'h0002 : 16'h0001,
                  {16'($urandom), 32'($urandom)}, 32'($urandom), tpa, $urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) fr[$urandom_range(12, 21)] ^= 8'($urandom_range(1, 255));
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 41) : fr_len;
            send(len, -1, $urandom_range(1, 3));
        end
        rnd_rdy = 0;
        drain(DEPTH + 2);
        check_eq("final_empty", 64'(REQ_VALID), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
